// File: rtl/vm1_bus_pkg.sv
// Shared definitions for 1801VM1 bus-slave responders: reply FSM states,
// CSR bit layout, default window/vector constants and the latched cycle descriptor.
package vm1_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_REPLY = 2'd2
  } rt_state_e;

  localparam int CSR_DONE_BIT = 7;
  localparam int CSR_IE_BIT   = 6;
  localparam int CSR_GO_BIT   = 0;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'o177130;
  localparam logic [15:0] DEFAULT_VECTOR    = 16'o000270;

  // What kind of bus cycle was accepted, captured when the FSM leaves IDLE.
  typedef struct packed {
    logic vec;
    logic data_sel;
    logic wr;
    logic byte_wr;
    logic hi;
  } cyc_t;

  function automatic logic [15:0] csr_word(input logic done, input logic ie);
    logic [15:0] w;
    w = '0;
    w[CSR_DONE_BIT] = done;
    w[CSR_IE_BIT]   = ie;
    return w;
  endfunction

endpackage

// File: rtl/vm1_reply_timer.sv
// Wait-state counter and IDLE/WAIT/REPLY handshake FSM for a VM1 bus slave;
// emits one-cycle fire/release strobes and drops back to IDLE on a master abort.
module vm1_reply_timer
  import vm1_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic start,
  input  logic din,
  input  logic dout,
  output logic load,
  output logic fire,
  output logic rel,
  output logic rply
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  rt_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       held;
  logic       bus_quiet;

  // Exactly one strobe must stay up; both or neither counts as abort.
  assign held      = din ^ dout;
  assign bus_quiet = !din && !dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          cnt_d   = WS;
        end
      end
      ST_WAIT: begin
        if (!held)               state_d = ST_IDLE;
        else if (cnt_q == 4'd0)  state_d = ST_REPLY;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      ST_REPLY: begin
        if (bus_quiet) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load = ce && (state_q == ST_IDLE) && start;
    fire = ce && (state_q == ST_WAIT) && (state_d == ST_REPLY);
    rel  = ce && (state_q == ST_REPLY) && (state_d == ST_IDLE);
    rply = (state_q == ST_REPLY);
  end

endmodule

// File: rtl/vm1_bus_responder.sv
// VM1 bus slave presenting a CSR/DATA register pair to one device core,
// with wait-stated RPLY and a vectored interrupt answered on IAKO reads.
module vm1_bus_responder
  import vm1_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] VECTOR      = DEFAULT_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        DIN,
  input  logic        DOUT,
  input  logic        WTBT,
  input  logic        IAKO,
  output logic [15:0] data_o,
  output logic        RPLY,
  output logic        VIRQ,
  input  logic        dev_done,
  input  logic [15:0] dev_rdata,
  output logic [15:0] dev_wdata,
  output logic        dev_go,
  output logic        dev_ie
);

  localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd2;

  logic        hit_csr, hit_data, vec_read, accept;
  logic        load, fire, rel, rply;
  logic        lo_wr, hi_wr;
  cyc_t        cyc_now, cyc_q, cyc_d;
  logic        done_q, done_d, ie_q, ie_d;
  logic        pend_q, pend_d, lvl_q, lvl_d;
  logic        go_q, go_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;

  assign hit_csr  = addr_i[15:1] == BASE_ADDR[15:1];
  assign hit_data = addr_i[15:1] == DATA_ADDR[15:1];
  assign vec_read = IAKO && DIN && !DOUT;
  // Any IAKO cycle bypasses address decode; unanswered ones are left to others.
  assign accept   = IAKO ? (vec_read && pend_q)
                         : ((DIN ^ DOUT) && (hit_csr || hit_data));

  always_comb begin
    cyc_now          = '0;
    cyc_now.vec      = IAKO;
    cyc_now.data_sel = hit_data;
    cyc_now.wr       = DOUT;
    cyc_now.byte_wr  = WTBT;
    cyc_now.hi       = addr_i[0];
  end

  vm1_reply_timer #(
    .WAIT_STATES(WAIT_STATES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (accept),
    .din   (DIN),
    .dout  (DOUT),
    .load  (load),
    .fire  (fire),
    .rel   (rel),
    .rply  (rply)
  );

  always_comb begin
    cyc_d   = load ? cyc_now : cyc_q;
    lo_wr   = fire && !cyc_q.vec && cyc_q.wr && !(cyc_q.byte_wr && cyc_q.hi);
    hi_wr   = fire && !cyc_q.vec && cyc_q.wr && !(cyc_q.byte_wr && !cyc_q.hi);
    done_d  = done_q;
    ie_d    = ie_q;
    go_d    = 1'b0;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    if (fire) begin
      if (cyc_q.vec)       rdata_d = VECTOR;
      else if (!cyc_q.wr)  rdata_d = cyc_q.data_sel ? dev_rdata : csr_word(done_q, ie_q);
      else                 rdata_d = '0;
    end else if (rel) begin
      rdata_d = '0;
    end

    if (fire && !cyc_q.vec && !cyc_q.wr && cyc_q.data_sel) done_d = 1'b0;
    if (dev_done) done_d = 1'b1;

    if (lo_wr) begin
      if (cyc_q.data_sel) begin
        wdata_d[7:0] = data_i[7:0];
      end else begin
        ie_d = data_i[CSR_IE_BIT];
        go_d = data_i[CSR_GO_BIT];
      end
    end
    if (hi_wr && cyc_q.data_sel) wdata_d[15:8] = data_i[15:8];

    // Pending is edge-triggered on DONE&IE; losing IE withdraws it at once.
    lvl_d  = done_q && ie_q;
    pend_d = pend_q;
    if (lvl_d && !lvl_q)     pend_d = 1'b1;
    if (fire && cyc_q.vec)   pend_d = 1'b0;
    if (!ie_d)               pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= '0;
      done_q  <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      lvl_q   <= 1'b0;
      go_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (ce) begin
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      lvl_q   <= lvl_d;
      go_q    <= go_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign RPLY      = rply;
  assign data_o    = rdata_q;
  assign VIRQ      = pend_q;
  assign dev_go    = go_q;
  assign dev_ie    = ie_q;
  assign dev_wdata = wdata_q;

endmodule

// File: tb/tb_vm1_bus_responder.sv
// Bench for vm1_bus_responder: unit 0 runs with WAIT_STATES=2, unit 1 with 4.
// Table vectors, hand-written corner sequences, then random traffic vs. a register-level model.
module tb_vm1_bus_responder;

  localparam logic [15:0] BASE = 16'o177130;
  localparam logic [15:0] DATA = 16'o177132;
  localparam logic [15:0] VEC  = 16'o000270;

  logic clk = 1'b0;
  logic reset, ce;
  logic [15:0] addr_s[2], data_s[2], dev_rdata_s[2];
  logic        din_s[2], dout_s[2], wtbt_s[2], iako_s[2], dev_done_s[2];
  logic [15:0] data_o_w[2], dev_wdata_w[2];
  logic        rply_w[2], virq_w[2], go_w[2], ie_w[2];

  int total = 0;
  int bad   = 0;

  logic        got_r, gofirst_r, virqfirst_r;
  logic [15:0] rd_r;
  int          lat_r, gos_r;

  always #5 clk = ~clk;

  vm1_bus_responder #(.BASE_ADDR(BASE), .WAIT_STATES(2), .VECTOR(VEC)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .addr_i(addr_s[0]), .data_i(data_s[0]),
    .DIN(din_s[0]), .DOUT(dout_s[0]), .WTBT(wtbt_s[0]), .IAKO(iako_s[0]),
    .data_o(data_o_w[0]), .RPLY(rply_w[0]), .VIRQ(virq_w[0]),
    .dev_done(dev_done_s[0]), .dev_rdata(dev_rdata_s[0]),
    .dev_wdata(dev_wdata_w[0]), .dev_go(go_w[0]), .dev_ie(ie_w[0])
  );

  vm1_bus_responder #(.BASE_ADDR(BASE), .WAIT_STATES(4), .VECTOR(VEC)) dut4 (
    .clk(clk), .reset(reset), .ce(ce),
    .addr_i(addr_s[1]), .data_i(data_s[1]),
    .DIN(din_s[1]), .DOUT(dout_s[1]), .WTBT(wtbt_s[1]), .IAKO(iako_s[1]),
    .data_o(data_o_w[1]), .RPLY(rply_w[1]), .VIRQ(virq_w[1]),
    .dev_done(dev_done_s[1]), .dev_rdata(dev_rdata_s[1]),
    .dev_wdata(dev_wdata_w[1]), .dev_go(go_w[1]), .dev_ie(ie_w[1])
  );

  typedef struct {
    int          op;      // 0 read, 1 write, 2 vector read, 3 DIN+DOUT together
    logic [15:0] addr;
    logic [15:0] wd;
    logic        wtbt;
    logic [15:0] rdin;
    logic        exp_got;
    logic [15:0] exp_rd;
    logic [15:0] exp_wdata;
    logic        exp_ie;
    int          exp_go;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int op, logic [15:0] addr, logic [15:0] wd, logic wtbt,
                              logic [15:0] rdin, logic eg, logic [15:0] erd,
                              logic [15:0] ewd, logic eie, int ego);
    vec_t v;
    v.op = op; v.addr = addr; v.wd = wd; v.wtbt = wtbt; v.rdin = rdin;
    v.exp_got = eg; v.exp_rd = erd; v.exp_wdata = ewd; v.exp_ie = eie; v.exp_go = ego;
    return v;
  endfunction

  function automatic logic [15:0] csr_val(logic d, logic ie);
    return {8'h00, d, ie, 6'b000000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_cycle(input int u, input int op, input logic [15:0] addr,
                          input logic [15:0] wd, input logic wt, input int budget);
    addr_s[u] = addr;
    data_s[u] = wd;
    wtbt_s[u] = wt;
    din_s[u]  = (op != 1);
    dout_s[u] = (op == 1 || op == 3);
    iako_s[u] = (op == 2);
    got_r = 1'b0; rd_r = '0; lat_r = 0; gos_r = 0; gofirst_r = 1'b0; virqfirst_r = 1'b0;
    for (int i = 1; i <= budget && !got_r; i++) begin
      tick();
      if (go_w[u]) gos_r++;
      if (rply_w[u]) begin
        got_r = 1'b1; lat_r = i; rd_r = data_o_w[u];
        gofirst_r = go_w[u]; virqfirst_r = virq_w[u];
      end
    end
    din_s[u] = 1'b0; dout_s[u] = 1'b0; iako_s[u] = 1'b0; wtbt_s[u] = 1'b0;
    tick();
    if (go_w[u]) gos_r++;
    if (got_r) begin
      check("rply_fall", rply_w[u], 1'b0);
      check("data_o_idle", data_o_w[u], 16'h0);
    end
    $display("txn u=%0d op=%0d addr=%o wd=%h got=%0d rd=%h lat=%0d go=%0d",
             u, op, addr, wd, got_r, rd_r, lat_r, gos_r);
  endtask

  task automatic pulse_done(input int u);
    dev_done_s[u] = 1'b1;
    tick();
    dev_done_s[u] = 1'b0;
    tick();
    tick();
    $display("txn u=%0d dev_done pulse", u);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic m_done, m_ie, m_pend, m_prev, e_got;
    logic [15:0] m_wdata, addr, wd, rdin, e_rd;
    logic wt;
    int op, r, e_go;

    reset = 1'b1;
    ce    = 1'b1;
    for (int u = 0; u < 2; u++) begin
      addr_s[u] = '0; data_s[u] = '0; dev_rdata_s[u] = '0;
      din_s[u] = 1'b0; dout_s[u] = 1'b0; wtbt_s[u] = 1'b0; iako_s[u] = 1'b0;
      dev_done_s[u] = 1'b0;
    end
    repeat (3) tick();
    check("rst_rply",  rply_w[0], 1'b0);
    check("rst_data",  data_o_w[0], 16'h0);
    check("rst_virq",  virq_w[0], 1'b0);
    check("rst_go",    go_w[0], 1'b0);
    check("rst_ie",    ie_w[0], 1'b0);
    check("rst_wdata", dev_wdata_w[0], 16'h0);
    reset = 1'b0;
    tick();

    // ---- table-driven register access vectors (unit 0) ----
    tbl.push_back(mk(0, BASE,         16'h0000, 0, 16'h0000, 1, 16'o000, 16'h0000, 0, 0));
    tbl.push_back(mk(1, DATA,         16'h00CD, 0, 16'h0000, 1, 16'h0,   16'h00CD, 0, 0));
    tbl.push_back(mk(1, 16'o177133,   16'hAB00, 1, 16'h0000, 1, 16'h0,   16'hABCD, 0, 0));
    tbl.push_back(mk(1, BASE,         16'o101,  0, 16'h0000, 1, 16'h0,   16'hABCD, 1, 1));
    tbl.push_back(mk(0, BASE,         16'h0000, 0, 16'h0000, 1, 16'o100, 16'hABCD, 1, 0));
    tbl.push_back(mk(1, 16'o177131,   16'hFFFF, 1, 16'h0000, 1, 16'h0,   16'hABCD, 1, 0));
    tbl.push_back(mk(0, BASE,         16'h0000, 0, 16'h0000, 1, 16'o100, 16'hABCD, 1, 0));
    tbl.push_back(mk(0, 16'o177140,   16'h0000, 0, 16'h0000, 0, 16'h0,   16'hABCD, 1, 0));
    tbl.push_back(mk(1, 16'o177126,   16'h1111, 0, 16'h0000, 0, 16'h0,   16'hABCD, 1, 0));
    tbl.push_back(mk(2, 16'h0000,     16'h0000, 0, 16'h0000, 0, 16'h0,   16'hABCD, 1, 0));
    tbl.push_back(mk(3, BASE,         16'o001,  0, 16'h0000, 0, 16'h0,   16'hABCD, 1, 0));
    tbl.push_back(mk(0, DATA,         16'h0000, 0, 16'h5A5A, 1, 16'h5A5A, 16'hABCD, 1, 0));
    tbl.push_back(mk(1, DATA,         16'h0011, 1, 16'h0000, 1, 16'h0,   16'hAB11, 1, 0));
    tbl.push_back(mk(1, BASE,         16'o000,  1, 16'h0000, 1, 16'h0,   16'hAB11, 0, 0));
    tbl.push_back(mk(0, BASE,         16'h0000, 0, 16'h0000, 1, 16'o000, 16'hAB11, 0, 0));
    foreach (tbl[i]) begin
      dev_rdata_s[0] = tbl[i].rdin;
      do_cycle(0, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].wtbt, 20);
      check($sformatf("tbl%0d_rply", i), got_r, tbl[i].exp_got);
      if (tbl[i].op == 0) check($sformatf("tbl%0d_rdata", i), rd_r, tbl[i].exp_rd);
      check($sformatf("tbl%0d_wdata", i), dev_wdata_w[0], tbl[i].exp_wdata);
      check($sformatf("tbl%0d_ie", i), ie_w[0], tbl[i].exp_ie);
      check($sformatf("tbl%0d_go", i), gos_r, tbl[i].exp_go);
    end

    // ---- DATA read timing and DONE clear ----
    pulse_done(0);
    do_cycle(0, 0, BASE, 16'h0, 1'b0, 20);
    check("csr_done_set", rd_r, 16'o200);
    dev_rdata_s[0] = 16'h1234;
    do_cycle(0, 0, DATA, 16'h0, 1'b0, 20);
    check("data_rd_got", got_r, 1'b1);
    check("data_rd_lat", lat_r, 4);
    check("data_rd_val", rd_r, 16'h1234);
    do_cycle(0, 0, BASE, 16'h0, 1'b0, 20);
    check("csr_done_clr", rd_r, 16'o000);

    // ---- GO pulse coincident with first RPLY ----
    do_cycle(0, 1, BASE, 16'o101, 1'b0, 20);
    check("go_count", gos_r, 1);
    check("go_with_rply", gofirst_r, 1'b1);
    do_cycle(0, 0, BASE, 16'h0, 1'b0, 20);
    check("csr_ie_only", rd_r, 16'o100);

    // ---- interrupt raise and vector acknowledge ----
    dev_done_s[0] = 1'b1;
    tick();
    dev_done_s[0] = 1'b0;
    check("virq_early", virq_w[0], 1'b0);
    tick();
    check("virq_rise", virq_w[0], 1'b1);
    do_cycle(0, 2, 16'h0, 16'h0, 1'b0, 20);
    check("vec_got", got_r, 1'b1);
    check("vec_val", rd_r, VEC);
    check("vec_lat", lat_r, 4);
    check("vec_virq_drop", virqfirst_r, 1'b0);
    do_cycle(0, 2, 16'h0, 16'h0, 1'b0, 20);
    check("vec2_no_rply", got_r, 1'b0);

    // ---- dev_done coincident with DATA-read clear (DONE=0 then DONE=1 before) ----
    for (int k = 0; k < 2; k++) begin
      if (k == 0) do_cycle(0, 0, DATA, 16'h0, 1'b0, 20);
      addr_s[0] = DATA;
      dev_rdata_s[0] = 16'h7777;
      din_s[0] = 1'b1;
      repeat (3) tick();
      dev_done_s[0] = 1'b1;
      tick();
      dev_done_s[0] = 1'b0;
      check($sformatf("simul%0d_rply", k), rply_w[0], 1'b1);
      din_s[0] = 1'b0;
      repeat (3) tick();
      $display("txn u=0 simultaneous DATA read + dev_done k=%0d", k);
      check($sformatf("simul%0d_virq", k), virq_w[0], (k == 0));
      do_cycle(0, 0, BASE, 16'h0, 1'b0, 20);
      check($sformatf("simul%0d_done", k), rd_r, 16'o300);
      if (k == 0) begin
        do_cycle(0, 2, 16'h0, 16'h0, 1'b0, 20);
        check("simul_vec_got", got_r, 1'b1);
      end
    end

    // ---- unit 1: WAIT_STATES=4 latency and master abort ----
    do_cycle(1, 0, BASE, 16'h0, 1'b0, 20);
    check("ws4_lat", lat_r, 6);
    check("ws4_csr", rd_r, 16'o000);
    pulse_done(1);
    addr_s[1] = DATA;
    dev_rdata_s[1] = 16'hBEEF;
    din_s[1] = 1'b1;
    repeat (2) tick();
    din_s[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rply_w[1] || data_o_w[1] != 16'h0) cnt++;
    end
    $display("txn u=1 aborted DATA read");
    check("abort_no_rply", cnt, 0);
    do_cycle(1, 0, BASE, 16'h0, 1'b0, 20);
    check("abort_done_kept", rd_r, 16'o200);

    // ---- reset while in REPLY ----
    addr_s[0] = BASE;
    din_s[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20 && !rply_w[0]; i++) begin
      tick();
      cnt++;
    end
    check("pre_reset_rply", rply_w[0], 1'b1);
    reset = 1'b1;
    tick();
    check("mid_rst_rply",  rply_w[0], 1'b0);
    check("mid_rst_data",  data_o_w[0], 16'h0);
    check("mid_rst_ie",    ie_w[0], 1'b0);
    check("mid_rst_wdata", dev_wdata_w[0], 16'h0);
    check("mid_rst_virq",  virq_w[0], 1'b0);
    din_s[0] = 1'b0;
    reset = 1'b0;
    tick();
    $display("txn u=0 reset during REPLY");
    do_cycle(0, 0, BASE, 16'h0, 1'b0, 20);
    check("post_rst_csr", rd_r, 16'o000);

    // ---- random traffic against register-level model ----
    m_done = 0; m_ie = 0; m_pend = 0; m_prev = 0; m_wdata = '0;
    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 7);
      op = 0; addr = BASE; wd = 16'($urandom); wt = 1'b0; rdin = 16'($urandom);
      e_got = 1'b0; e_rd = '0; e_go = 0;
      case (r)
        0: begin e_got = 1; e_rd = csr_val(m_done, m_ie); end
        1: begin op = 1; e_got = 1; m_ie = wd[6]; e_go = int'(wd[0]); end
        2: begin
          op = 1; wt = 1'b1; addr = BASE + 16'($urandom_range(0, 1)); e_got = 1;
          if (!addr[0]) begin m_ie = wd[6]; e_go = int'(wd[0]); end
        end
        3: begin addr = DATA; e_got = 1; e_rd = rdin; m_done = 0; end
        4: begin
          op = 1; wt = 1'($urandom_range(0, 1)); e_got = 1;
          addr = DATA + (wt ? 16'($urandom_range(0, 1)) : 16'd0);
          if (!wt)          m_wdata = wd;
          else if (addr[0]) m_wdata[15:8] = wd[15:8];
          else              m_wdata[7:0] = wd[7:0];
        end
        5: begin
          op = $urandom_range(0, 1);
          addr = 16'($urandom);
          if (addr[15:2] == BASE[15:2]) addr[8] = ~addr[8];
        end
        6: begin
          op = 2; addr = 16'h0;
          if (m_pend) begin e_got = 1; e_rd = VEC; m_pend = 0; end
        end
        default: m_done = 1;
      endcase
      if (r == 7) begin
        pulse_done(0);
      end else begin
        dev_rdata_s[0] = rdin;
        do_cycle(0, op, addr, wd, wt, 20);
        check($sformatf("rnd%0d_rply", n), got_r, e_got);
        if (e_got && op != 1) check($sformatf("rnd%0d_rdata", n), rd_r, e_rd);
        if (e_got) check($sformatf("rnd%0d_lat", n), lat_r, 4);
        check($sformatf("rnd%0d_go", n), gos_r, e_go);
      end
      if ((m_done && m_ie) && !m_prev) m_pend = 1;
      if (!m_ie) m_pend = 0;
      m_prev = m_done && m_ie;
      check($sformatf("rnd%0d_virq", n), virq_w[0], m_pend);
      check($sformatf("rnd%0d_ie", n), ie_w[0], m_ie);
      check($sformatf("rnd%0d_wdata", n), dev_wdata_w[0], m_wdata);
    end
    do_cycle(0, 0, BASE, 16'h0, 1'b0, 20);
    check("rnd_final_csr", rd_r, csr_val(m_done, m_ie));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
